// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding selects, load-use stalls and post-branch flushes.
// Optional cycle statistics outputs STALL_CNT/FLUSH_CNT are built when HAZARD_STATS_EN is defined.
module hazard_unit #(
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ID_RN,
  input  logic [3:0]  ID_RM,
  input  logic [3:0]  ID_RD,
  input  logic        ID_USE_RN,
  input  logic        ID_USE_RM,
  input  logic        ID_USE_RD,
  input  logic [3:0]  EX_RD,
  input  logic        EX_RF_LE,
  input  logic        EX_L,
  input  logic [3:0]  MEM_RD,
  input  logic [3:0]  WB_RD,
  input  logic        MEM_RF_LE,
  input  logic        WB_RF_LE,
  input  logic        BRANCH_TAKEN,
  output logic        stall,
  output logic        flush,
  output logic        PC_LE,
  output logic        IF_ID_LE,
  output logic [1:0]  FWD_A,
  output logic [1:0]  FWD_B,
  output logic [1:0]  FWD_C
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT
`endif
);

  typedef enum logic [1:0] {StRun, StLstall, StFlush} state_e;

  // Cycles remaining after the triggering cycle, which is itself spent in StRun.
  localparam logic [2:0] LoadCnt  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FlushCnt = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu_hit;

  function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic use_src,
                                         input logic [3:0] ex_rd, input logic ex_le,
                                         input logic ex_l, input logic [3:0] mem_rd,
                                         input logic mem_le, input logic [3:0] wb_rd,
                                         input logic wb_le);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src) begin
      if (ex_le && !ex_l && (ex_rd == src)) sel = 2'b01;
      else if (mem_le && (mem_rd == src))   sel = 2'b10;
      else if (wb_le && (wb_rd == src))     sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    FWD_A = fwd_sel(ID_RN, ID_USE_RN, EX_RD, EX_RF_LE, EX_L, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
    FWD_B = fwd_sel(ID_RM, ID_USE_RM, EX_RD, EX_RF_LE, EX_L, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
    FWD_C = fwd_sel(ID_RD, ID_USE_RD, EX_RD, EX_RF_LE, EX_L, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
  end

  assign lu_hit = EX_RF_LE & EX_L & ((ID_USE_RN & (ID_RN == EX_RD)) |
                                     (ID_USE_RM & (ID_RM == EX_RD)) |
                                     (ID_USE_RD & (ID_RD == EX_RD)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    flush    = 1'b0;
    PC_LE    = 1'b1;
    IF_ID_LE = 1'b1;
    unique case (state_q)
      StRun: begin
        if (BRANCH_TAKEN) begin
          flush = 1'b1;
          if (FlushCnt != 3'd0) begin
            state_d = StFlush;
            cnt_d   = FlushCnt;
          end
        end else if (lu_hit) begin
          stall    = 1'b1;
          PC_LE    = 1'b0;
          IF_ID_LE = 1'b0;
          if (LoadCnt != 3'd0) begin
            state_d = StLstall;
            cnt_d   = LoadCnt;
          end
        end
      end
      StLstall: begin
        // A taken branch squashes the stalled instruction, so the stall is abandoned.
        if (BRANCH_TAKEN) begin
          flush = 1'b1;
          if (FlushCnt != 3'd0) begin
            state_d = StFlush;
            cnt_d   = FlushCnt;
          end else begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end
        end else begin
          stall    = 1'b1;
          PC_LE    = 1'b0;
          IF_ID_LE = 1'b0;
          if (cnt_q <= 3'd1) begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (BRANCH_TAKEN && (FlushCnt != 3'd0)) begin
          cnt_d = FlushCnt;
        end else if (cnt_q <= 3'd1) begin
          state_d = StRun;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      STALL_CNT <= 16'd0;
      FLUSH_CNT <= 16'd0;
    end else begin
      if (stall && (STALL_CNT != 16'hFFFF)) STALL_CNT <= STALL_CNT + 16'd1;
      if (flush && (FLUSH_CNT != 16'hFFFF)) FLUSH_CNT <= FLUSH_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding vector table plus stall/flush/reset sequences.
module tb_hazard_unit;

  localparam int unsigned LL = 3;
  localparam int unsigned FC = 2;

  logic       clk, rst_n;
  logic [3:0] ID_RN, ID_RM, ID_RD, EX_RD, MEM_RD, WB_RD;
  logic       ID_USE_RN, ID_USE_RM, ID_USE_RD, EX_RF_LE, EX_L, MEM_RF_LE, WB_RF_LE;
  logic       BRANCH_TAKEN;
  logic       stall, flush, PC_LE, IF_ID_LE;
  logic [1:0] FWD_A, FWD_B, FWD_C;
`ifdef HAZARD_STATS_EN
  logic [15:0] STALL_CNT, FLUSH_CNT;
`endif

  hazard_unit #(
    .LOAD_LAT    (LL),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ID_RN       (ID_RN),
    .ID_RM       (ID_RM),
    .ID_RD       (ID_RD),
    .ID_USE_RN   (ID_USE_RN),
    .ID_USE_RM   (ID_USE_RM),
    .ID_USE_RD   (ID_USE_RD),
    .EX_RD       (EX_RD),
    .EX_RF_LE    (EX_RF_LE),
    .EX_L        (EX_L),
    .MEM_RD      (MEM_RD),
    .WB_RD       (WB_RD),
    .MEM_RF_LE   (MEM_RF_LE),
    .WB_RF_LE    (WB_RF_LE),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .stall       (stall),
    .flush       (flush),
    .PC_LE       (PC_LE),
    .IF_ID_LE    (IF_ID_LE),
    .FWD_A       (FWD_A),
    .FWD_B       (FWD_B),
    .FWD_C       (FWD_C)
`ifdef HAZARD_STATS_EN
    ,
    .STALL_CNT   (STALL_CNT),
    .FLUSH_CNT   (FLUSH_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rn, rm, rd;
    logic [2:0] use_v;  // {rn, rm, rd}
    logic [3:0] ex_rd;
    logic       ex_le, ex_l;
    logic [3:0] mem_rd;
    logic       mem_le;
    logic [3:0] wb_rd;
    logic       wb_le;
    logic [1:0] fa, fb, fc;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_RN = 0; ID_RM = 0; ID_RD = 0;
    ID_USE_RN = 0; ID_USE_RM = 0; ID_USE_RD = 0;
    EX_RD = 0; EX_RF_LE = 0; EX_L = 0;
    MEM_RD = 0; MEM_RF_LE = 0; WB_RD = 0; WB_RF_LE = 0;
    BRANCH_TAKEN = 0;
  endtask

  task automatic set_hit();
    EX_L = 1; EX_RF_LE = 1; EX_RD = 5; ID_RM = 5; ID_USE_RM = 1;
  endtask

  task automatic chk_ctl(input string name, input logic s, input logic f);
    chk({name, "_stall"}, {15'd0, stall}, {15'd0, s});
    chk({name, "_flush"}, {15'd0, flush}, {15'd0, f});
    chk({name, "_pc_le"}, {15'd0, PC_LE}, {15'd0, !s});
    chk({name, "_ifid_le"}, {15'd0, IF_ID_LE}, {15'd0, !s});
  endtask

  // Single-cycle load-use trigger; the stall must persist LL cycles from FSM state alone.
  task automatic run_load_use();
    tick(); idle(); set_hit();
    @(negedge clk); chk_ctl("lu_c0", 1'b1, 1'b0);
    chk("lu_fwd_b", {14'd0, FWD_B}, 16'd0);
    for (int k = 1; k < int'(LL); k++) begin
      tick(); idle();
      @(negedge clk); chk_ctl($sformatf("lu_c%0d", k), 1'b1, 1'b0);
    end
    tick();
    @(negedge clk); chk_ctl("lu_end", 1'b0, 1'b0);
  endtask

  task automatic run_branch();
    tick(); idle(); BRANCH_TAKEN = 1;
    @(negedge clk); chk_ctl("br_c0", 1'b0, 1'b1);
    for (int k = 1; k < int'(FC); k++) begin
      tick(); BRANCH_TAKEN = 0;
      @(negedge clk); chk_ctl($sformatf("br_c%0d", k), 1'b0, 1'b1);
    end
    tick(); BRANCH_TAKEN = 0;
    @(negedge clk); chk_ctl("br_end", 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
                 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{4'd3, 4'd0, 4'd0, 3'b100, 4'd3, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1,
                 2'b01, 2'b00, 2'b00};
    vecs[2]  = '{4'd3, 4'd0, 4'd0, 3'b100, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1,
                 2'b10, 2'b00, 2'b00};
    vecs[3]  = '{4'd3, 4'd0, 4'd0, 3'b100, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 4'd3, 1'b1,
                 2'b11, 2'b00, 2'b00};
    vecs[4]  = '{4'd3, 4'd0, 4'd0, 3'b100, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0,
                 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{4'd3, 4'd3, 4'd3, 3'b000, 4'd3, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1,
                 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{4'd3, 4'd7, 4'd9, 3'b111, 4'd7, 1'b1, 1'b0, 4'd9, 1'b1, 4'd3, 1'b1,
                 2'b11, 2'b01, 2'b10};
    vecs[7]  = '{4'd4, 4'd2, 4'd6, 3'b010, 4'd4, 1'b1, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1,
                 2'b00, 2'b10, 2'b00};
    vecs[8]  = '{4'd5, 4'd0, 4'd0, 3'b100, 4'd5, 1'b0, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1,
                 2'b11, 2'b00, 2'b00};
    vecs[9]  = '{4'd0, 4'd0, 4'd0, 3'b001, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1,
                 2'b00, 2'b00, 2'b01};
    vecs[10] = '{4'd8, 4'd8, 4'd8, 3'b111, 4'd1, 1'b1, 1'b0, 4'd8, 1'b1, 4'd8, 1'b1,
                 2'b10, 2'b10, 2'b10};

    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0);
    chk("reset_fwd_a", {14'd0, FWD_A}, 16'd0);
    chk("reset_fwd_b", {14'd0, FWD_B}, 16'd0);
    chk("reset_fwd_c", {14'd0, FWD_C}, 16'd0);
`ifdef HAZARD_STATS_EN
    chk("reset_stall_cnt", STALL_CNT, 16'd0);
    chk("reset_flush_cnt", FLUSH_CNT, 16'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      tick();
      idle();
      {ID_RN, ID_RM, ID_RD} = {vecs[i].rn, vecs[i].rm, vecs[i].rd};
      {ID_USE_RN, ID_USE_RM, ID_USE_RD} = vecs[i].use_v;
      EX_RD = vecs[i].ex_rd; EX_RF_LE = vecs[i].ex_le; EX_L = vecs[i].ex_l;
      MEM_RD = vecs[i].mem_rd; MEM_RF_LE = vecs[i].mem_le;
      WB_RD = vecs[i].wb_rd; WB_RF_LE = vecs[i].wb_le;
      @(negedge clk);
      chk($sformatf("v%0d_fwd_a", i), {14'd0, FWD_A}, {14'd0, vecs[i].fa});
      chk($sformatf("v%0d_fwd_b", i), {14'd0, FWD_B}, {14'd0, vecs[i].fb});
      chk($sformatf("v%0d_fwd_c", i), {14'd0, FWD_C}, {14'd0, vecs[i].fc});
      chk_ctl($sformatf("v%0d", i), 1'b0, 1'b0);
    end

    run_load_use();

    // Store-data source alone triggers a load-use stall.
    tick(); idle();
    EX_L = 1; EX_RF_LE = 1; EX_RD = 9; ID_RD = 9; ID_USE_RD = 1;
    @(negedge clk); chk_ctl("lu_src_c", 1'b1, 1'b0);
    for (int k = 1; k < int'(LL); k++) begin
      tick(); idle();
    end
    tick();
    @(negedge clk); chk_ctl("lu_src_c_end", 1'b0, 1'b0);

    run_branch();

    // Branch and load-use hit together: flush wins, hit ignored while flushing.
    tick(); idle(); set_hit(); BRANCH_TAKEN = 1;
    @(negedge clk); chk_ctl("brlu_c0", 1'b0, 1'b1);
    for (int k = 1; k < int'(FC); k++) begin
      tick(); BRANCH_TAKEN = 0;
      @(negedge clk); chk_ctl($sformatf("brlu_c%0d", k), 1'b0, 1'b1);
    end
    tick(); idle();
    @(negedge clk); chk_ctl("brlu_end", 1'b0, 1'b0);

    // Branch in the second stall cycle aborts the stall.
    tick(); idle(); set_hit();
    @(negedge clk); chk_ctl("bis_c0", 1'b1, 1'b0);
    tick(); idle(); BRANCH_TAKEN = 1;
    @(negedge clk); chk_ctl("bis_c1", 1'b0, 1'b1);
    for (int k = 1; k < int'(FC); k++) begin
      tick(); BRANCH_TAKEN = 0;
      @(negedge clk); chk_ctl($sformatf("bis_fl%0d", k), 1'b0, 1'b1);
    end
    BRANCH_TAKEN = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk); chk_ctl($sformatf("bis_after%0d", k), 1'b0, 1'b0);
    end

    // Reset mid-stall ends the sequence at that edge.
    tick(); idle(); set_hit();
    @(negedge clk); chk_ctl("rst_mid_c0", 1'b1, 1'b0);
    tick(); idle(); rst_n = 0;
    @(negedge clk); chk_ctl("rst_mid_c1", 1'b1, 1'b0);
    tick(); rst_n = 1;
    @(negedge clk); chk_ctl("rst_mid_after", 1'b0, 1'b0);

`ifdef HAZARD_STATS_EN
    chk("st_clr_stall", STALL_CNT, 16'd0);
    chk("st_clr_flush", FLUSH_CNT, 16'd0);
    run_load_use();
    run_branch();
    chk("st_stall_cnt", STALL_CNT, 16'(LL));
    chk("st_flush_cnt", FLUSH_CNT, 16'(FC));
    tick(); rst_n = 0;
    tick(); rst_n = 1;
    @(negedge clk);
    chk("st_rst_stall", STALL_CNT, 16'd0);
    chk("st_rst_flush", FLUSH_CNT, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
